cci_mpf_shim_vtp_miss_arb: RTL and testbench

Serializes TLB misses from the two VTP lookup ports onto the single page-table walker. Holds one pending miss per port, drops duplicate VAs, issues one walk at a time in round-robin order, and retires it on the matching TLB fill, a not-present response, or a timeout. Sits between the TLB miss outputs and the walker request port; it watches the fill path to detect completion.

---
 rtl/cci_mpf_shim_vtp_miss_arb_pkg.sv | 16 +
 rtl/cci_mpf_shim_vtp_miss_slot.sv | 59 +++++
 rtl/cci_mpf_shim_vtp_miss_arb.sv | 188 ++++++++++++++++++
 tb/tb_cci_mpf_shim_vtp_miss_arb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cci_mpf_shim_vtp_miss_arb_pkg.sv
// Shared VTP types used by the TLB miss arbiter.
//   t_tlb_4kb_va_page_idx        : 36-bit 4KB virtual page index
//   t_cci_mpf_vtp_miss_arb_state : arbiter FSM state, exported for debug
package cci_mpf_shim_vtp_miss_arb_pkg;

  localparam int VA_PAGE_IDX_W = 36;

  typedef logic [VA_PAGE_IDX_W-1:0] t_tlb_4kb_va_page_idx;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WALK  = 2'd2
  } t_cci_mpf_vtp_miss_arb_state;

endpackage

// File: rtl/cci_mpf_shim_vtp_miss_slot.sv
// One pending-miss slot of the VTP miss arbiter.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   cap_en_i         : allocate the slot with cap_va_i (only when free)
//   clr_en_i         : free the slot (wins over capture)
//   dup_cmp_va_i     : VA compared against the held VA for capture dedup
//   cur_cmp_va_i     : VA compared against the held VA for completion clear
//   valid_o, va_o    : slot contents
//   miss_rdy_o       : slot is free
//   dup_hit_o        : slot valid and holds dup_cmp_va_i
//   cur_hit_o        : slot valid and holds cur_cmp_va_i
module cci_mpf_shim_vtp_miss_slot
  import cci_mpf_shim_vtp_miss_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cap_en_i,
  input  t_tlb_4kb_va_page_idx cap_va_i,
  input  logic                 clr_en_i,
  input  t_tlb_4kb_va_page_idx dup_cmp_va_i,
  input  t_tlb_4kb_va_page_idx cur_cmp_va_i,
  output logic                 valid_o,
  output t_tlb_4kb_va_page_idx va_o,
  output logic                 miss_rdy_o,
  output logic                 dup_hit_o,
  output logic                 cur_hit_o
);

  logic                 valid_q, valid_d;
  t_tlb_4kb_va_page_idx va_q, va_d;

  always_comb begin
    valid_d = valid_q;
    va_d    = va_q;
    if (clr_en_i) begin
      valid_d = 1'b0;
    end else if (cap_en_i) begin
      valid_d = 1'b1;
      va_d    = cap_va_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      va_q    <= '0;
    end else begin
      valid_q <= valid_d;
      va_q    <= va_d;
    end
  end

  assign valid_o    = valid_q;
  assign va_o       = va_q;
  assign miss_rdy_o = !valid_q;
  assign dup_hit_o  = valid_q && (va_q == dup_cmp_va_i);
  assign cur_hit_o  = valid_q && (va_q == cur_cmp_va_i);

endmodule

// File: rtl/cci_mpf_shim_vtp_miss_arb.sv
// Serializes TLB misses from two VTP lookup ports onto one page-table walker.
// Holds one pending miss per port, drops duplicate VAs, issues one walk at a
// time in round-robin order and retires it on matching fill, not-present or
// timeout.
// Handshakes: a request transfers on a cycle where valid and ready are both
// high (missEn&missRdy, walkReqEn&walkReqRdy); valid sources hold their
// payload stable until the transfer; walkFillEn is a single-cycle event.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   missEn/missVA/missRdy   : per-port miss request channel
//   walkReqEn/VA/Rdy        : walker request channel
//   walkFillEn/VA           : accepted TLB fill (completion watch)
//   walkNotPresent          : walker reports VA absent from page table
//   busy                    : a walk is issued or in flight
//   errNotPresent/errTimeout: sticky error flags, errVA = last error VA
//   walkCnt                 : completed walks, wrapping
//   dbgState                : FSM state for debug
module cci_mpf_shim_vtp_miss_arb
  import cci_mpf_shim_vtp_miss_arb_pkg::*;
#(
  parameter int WALK_TIMEOUT = 4096
)
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  missEn,
  input  t_tlb_4kb_va_page_idx        missVA [2],
  output logic [1:0]                  missRdy,
  output logic                        walkReqEn,
  output t_tlb_4kb_va_page_idx        walkReqVA,
  input  logic                        walkReqRdy,
  input  logic                        walkFillEn,
  input  t_tlb_4kb_va_page_idx        walkFillVA,
  input  logic                        walkNotPresent,
  output logic                        busy,
  output logic                        errNotPresent,
  output logic                        errTimeout,
  output t_tlb_4kb_va_page_idx        errVA,
  output logic [15:0]                 walkCnt,
  output t_cci_mpf_vtp_miss_arb_state dbgState
);

  localparam int TW = (WALK_TIMEOUT > 1) ? $clog2(WALK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(WALK_TIMEOUT - 1);

  t_cci_mpf_vtp_miss_arb_state state_q, state_d;
  logic                        grant_q, grant_d;
  logic                        rr_q, rr_d;
  t_tlb_4kb_va_page_idx        cur_va_q, cur_va_d;
  logic [TW-1:0]               timer_q, timer_d;
  logic                        err_np_q, err_np_d;
  logic                        err_to_q, err_to_d;
  t_tlb_4kb_va_page_idx        err_va_q, err_va_d;
  logic [15:0]                 walk_cnt_q, walk_cnt_d;

  logic [1:0]           slot_valid;
  t_tlb_4kb_va_page_idx slot_va [2];
  logic [1:0]           accept, dup, cap_en, clr_en, dup_hit, cur_hit;
  logic                 in_flight;
  logic                 done;

  assign in_flight = (state_q != IDLE);

  // Slot p's dedup comparator checks the other port's incoming VA, so
  // dup_hit[p] means "port !p is missing on a VA that slot p already holds".
  for (genvar p = 0; p < 2; p++) begin : g_slot
    cci_mpf_shim_vtp_miss_slot u_slot (
      .clk          (clk),
      .reset        (reset),
      .cap_en_i     (cap_en[p]),
      .cap_va_i     (missVA[p]),
      .clr_en_i     (clr_en[p]),
      .dup_cmp_va_i (missVA[1-p]),
      .cur_cmp_va_i (cur_va_q),
      .valid_o      (slot_valid[p]),
      .va_o         (slot_va[p]),
      .miss_rdy_o   (missRdy[p]),
      .dup_hit_o    (dup_hit[p]),
      .cur_hit_o    (cur_hit[p])
    );

    assert property (@(posedge clk) disable iff (reset) !(missEn[p] && !missRdy[p]))
      else $error("miss arb: missEn on port %0d while its slot is occupied", p);
  end

  // Capture / dedup. A duplicate is accepted but allocates nothing. When both
  // ports present the same VA in one cycle port 0 owns it.
  always_comb begin
    accept[0] = missEn[0] && missRdy[0];
    accept[1] = missEn[1] && missRdy[1];
    dup[0]    = (in_flight && (missVA[0] == cur_va_q)) || dup_hit[1];
    dup[1]    = (in_flight && (missVA[1] == cur_va_q)) || dup_hit[0] ||
                (accept[0] && (missVA[0] == missVA[1]));
    cap_en[0] = accept[0] && !dup[0];
    cap_en[1] = accept[1] && !dup[1];
  end

  // FSM next state plus all datapath registers.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    cur_va_d   = cur_va_q;
    timer_d    = timer_q;
    err_np_d   = err_np_q;
    err_to_d   = err_to_q;
    err_va_d   = err_va_q;
    walk_cnt_d = walk_cnt_q;
    clr_en     = '0;
    done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|slot_valid) begin
          grant_d  = slot_valid[rr_q] ? rr_q : !rr_q;
          cur_va_d = slot_va[grant_d];
          state_d  = ISSUE;
        end
      end

      ISSUE: begin
        if (walkReqRdy) begin
          state_d = WALK;
          timer_d = '0;
        end
      end

      WALK: begin
        timer_d = timer_q + TW'(1);
        if (walkFillEn && (walkFillVA == cur_va_q)) begin
          done = 1'b1;
        end else if (walkNotPresent) begin
          done     = 1'b1;
          err_np_d = 1'b1;
          err_va_d = cur_va_q;
        end else if (timer_q == TIMER_LAST) begin
          done     = 1'b1;
          err_to_d = 1'b1;
          err_va_d = cur_va_q;
        end

        if (done) begin
          clr_en[grant_q]  = 1'b1;
          clr_en[!grant_q] = cur_hit[!grant_q];
          rr_d             = !grant_q;
          walk_cnt_d       = walk_cnt_q + 16'd1;
          state_d          = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      rr_q       <= 1'b0;
      cur_va_q   <= '0;
      timer_q    <= '0;
      err_np_q   <= 1'b0;
      err_to_q   <= 1'b0;
      err_va_q   <= '0;
      walk_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      cur_va_q   <= cur_va_d;
      timer_q    <= timer_d;
      err_np_q   <= err_np_d;
      err_to_q   <= err_to_d;
      err_va_q   <= err_va_d;
      walk_cnt_q <= walk_cnt_d;
    end
  end

  assign walkReqEn     = (state_q == ISSUE);
  assign walkReqVA     = walkReqEn ? cur_va_q : '0;
  assign busy          = in_flight;
  assign errNotPresent = err_np_q;
  assign errTimeout    = err_to_q;
  assign errVA         = err_va_q;
  assign walkCnt       = walk_cnt_q;
  assign dbgState      = state_q;

endmodule

// File: tb/tb_cci_mpf_shim_vtp_miss_arb.sv
module tb_cci_mpf_shim_vtp_miss_arb;
  import cci_mpf_shim_vtp_miss_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]                  missEn;
  t_tlb_4kb_va_page_idx        missVA [2];
  logic [1:0]                  missRdy;
  logic                        walkReqEn;
  t_tlb_4kb_va_page_idx        walkReqVA;
  logic                        walkReqRdy;
  logic                        walkFillEn;
  t_tlb_4kb_va_page_idx        walkFillVA;
  logic                        walkNotPresent;
  logic                        busy;
  logic                        errNotPresent;
  logic                        errTimeout;
  t_tlb_4kb_va_page_idx        errVA;
  logic [15:0]                 walkCnt;
  t_cci_mpf_vtp_miss_arb_state dbgState;

  cci_mpf_shim_vtp_miss_arb #(.WALK_TIMEOUT(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .missEn         (missEn),
    .missVA         (missVA),
    .missRdy        (missRdy),
    .walkReqEn      (walkReqEn),
    .walkReqVA      (walkReqVA),
    .walkReqRdy     (walkReqRdy),
    .walkFillEn     (walkFillEn),
    .walkFillVA     (walkFillVA),
    .walkNotPresent (walkNotPresent),
    .busy           (busy),
    .errNotPresent  (errNotPresent),
    .errTimeout     (errTimeout),
    .errVA          (errVA),
    .walkCnt        (walkCnt),
    .dbgState       (dbgState)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- scoreboard ----------------
  logic [35:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Every accepted walk request must be the next expected VA.
  always @(negedge clk) begin
    if (!reset && walkReqEn && walkReqRdy) begin
      if (exp_q.size() == 0) begin
        chk("walk_unexpected", {28'd0, walkReqVA}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("walk_va", {28'd0, walkReqVA}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic set_miss(input logic [1:0] en, input logic [35:0] va0, input logic [35:0] va1);
    missEn    = en;
    missVA[0] = va0;
    missVA[1] = va1;
  endtask

  task automatic set_fill(input logic en, input logic [35:0] va);
    walkFillEn = en;
    walkFillVA = va;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    set_miss(2'b00, '0, '0);
    walkReqRdy     = 1'b1;
    set_fill(1'b0, '0);
    walkNotPresent = 1'b0;
    #1;

    // Reset values (reset held from time 0)
    chk("rst_missRdy", 64'(missRdy), 64'h3);
    chk("rst_walkReqEn", 64'(walkReqEn), 64'h0);
    chk("rst_walkReqVA", {28'd0, walkReqVA}, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_errs", {62'd0, errNotPresent, errTimeout}, 64'h0);
    chk("rst_errVA", {28'd0, errVA}, 64'h0);
    chk("rst_walkCnt", 64'(walkCnt), 64'h0);
    chk("rst_state", 64'(dbgState), 64'(IDLE));
    step(2);
    reset = 1'b0;
    step(1);

    // T1: single miss on port 0, fill at t+5
    set_miss(2'b01, 36'h123, '0);            // cycle t
    exp_q.push_back(36'h123);
    step(1);                                   // t+1
    set_miss(2'b00, '0, '0);
    chk("t1_rdy_t1", 64'(missRdy), 64'h2);
    chk("t1_en_t1", 64'(walkReqEn), 64'h0);
    step(1);                                   // t+2
    chk("t1_en_t2", 64'(walkReqEn), 64'h1);
    chk("t1_busy_t2", 64'(busy), 64'h1);
    step(1);                                   // t+3
    chk("t1_en_t3", 64'(walkReqEn), 64'h0);
    chk("t1_state_t3", 64'(dbgState), 64'(WALK));
    step(1);                                   // t+4
    chk("t1_en_t4", 64'(walkReqEn), 64'h0);
    step(1);                                   // t+5
    set_fill(1'b1, 36'h123);
    chk("t1_rdy_t5", 64'(missRdy[0]), 64'h0);
    step(1);                                   // t+6
    set_fill(1'b0, '0);
    chk("t1_rdy_t6", 64'(missRdy[0]), 64'h1);
    chk("t1_walkCnt", 64'(walkCnt), 64'h1);
    chk("t1_state_t6", 64'(dbgState), 64'(IDLE));
    chk("t1_busy_t6", 64'(busy), 64'h0);

    // T2: both ports miss in one cycle with rr=0
    do_reset();
    set_miss(2'b11, 36'h10, 36'h20);          // cycle u
    exp_q.push_back(36'h10);
    exp_q.push_back(36'h20);
    step(1);                                   // u+1
    set_miss(2'b00, '0, '0);
    chk("t2_rdy_u1", 64'(missRdy), 64'h0);
    step(1);                                   // u+2
    chk("t2_reqva_u2", {28'd0, walkReqVA}, 64'h10);
    step(1);                                   // u+3 (WALK)
    set_fill(1'b1, 36'h10);
    step(1);                                   // u+4
    set_fill(1'b0, '0);
    chk("t2_rdy_u4", 64'(missRdy), 64'h1);
    chk("t2_en_u4", 64'(walkReqEn), 64'h0);
    step(1);                                   // u+5
    chk("t2_en_u5", 64'(walkReqEn), 64'h1);
    chk("t2_reqva_u5", {28'd0, walkReqVA}, 64'h20);
    step(1);                                   // u+6 (WALK)
    set_fill(1'b1, 36'h20);
    step(1);                                   // u+7
    set_fill(1'b0, '0);
    chk("t2_rdy_u7", 64'(missRdy), 64'h3);
    chk("t2_walkCnt", 64'(walkCnt), 64'h2);

    // T3: same VA on both ports, then port 1 re-misses it mid-walk
    set_miss(2'b11, 36'h55, 36'h55);          // cycle v (rr back to 0)
    exp_q.push_back(36'h55);
    step(1);                                   // v+1
    set_miss(2'b00, '0, '0);
    chk("t3_rdy_v1", 64'(missRdy), 64'h2);
    step(2);                                   // v+3 (WALK)
    set_miss(2'b10, '0, 36'h55);
    step(1);                                   // v+4
    set_miss(2'b00, '0, '0);
    chk("t3_rdy1_v4", 64'(missRdy[1]), 64'h1);
    set_fill(1'b1, 36'h55);
    step(1);                                   // v+5
    set_fill(1'b0, '0);
    chk("t3_rdy_v5", 64'(missRdy), 64'h3);
    chk("t3_walkCnt", 64'(walkCnt), 64'h3);
    step(1);                                   // v+6
    chk("t3_no_second_walk", 64'(walkReqEn), 64'h0);
    chk("t3_busy_v6", 64'(busy), 64'h0);

    // T4: non-matching fill ignored, then not-present
    set_miss(2'b01, 36'h10, '0);              // cycle w (rr=1, only port 0 valid)
    exp_q.push_back(36'h10);
    step(1);
    set_miss(2'b00, '0, '0);
    step(2);                                   // w+3 (WALK)
    set_fill(1'b1, 36'h99);
    step(1);                                   // w+4
    set_fill(1'b0, '0);
    chk("t4_busy_after_99", 64'(busy), 64'h1);
    chk("t4_rdy_after_99", 64'(missRdy[0]), 64'h0);
    chk("t4_np_before", 64'(errNotPresent), 64'h0);
    walkNotPresent = 1'b1;
    step(1);                                   // w+5
    walkNotPresent = 1'b0;
    chk("t4_np", 64'(errNotPresent), 64'h1);
    chk("t4_errVA", {28'd0, errVA}, 64'h10);
    chk("t4_rdy_freed", 64'(missRdy[0]), 64'h1);
    chk("t4_to_clear", 64'(errTimeout), 64'h0);
    chk("t4_walkCnt", 64'(walkCnt), 64'h4);

    // Not-present in IDLE is ignored
    walkNotPresent = 1'b1;
    step(1);
    walkNotPresent = 1'b0;
    chk("idle_np_cnt", 64'(walkCnt), 64'h4);

    // T5: timeout on port 1 walk (WALK_TIMEOUT=8)
    set_miss(2'b10, '0, 36'h77);              // cycle x
    exp_q.push_back(36'h77);
    step(1);
    set_miss(2'b00, '0, '0);
    step(2);                                   // x+3, first WALK cycle
    chk("t5_state_walk", 64'(dbgState), 64'(WALK));
    step(7);                                   // x+10, timer at last value
    chk("t5_to_early", 64'(errTimeout), 64'h0);
    chk("t5_busy_x10", 64'(busy), 64'h1);
    step(1);                                   // x+11
    chk("t5_to", 64'(errTimeout), 64'h1);
    chk("t5_errVA", {28'd0, errVA}, 64'h77);
    chk("t5_state_idle", 64'(dbgState), 64'(IDLE));
    chk("t5_rdy", 64'(missRdy), 64'h3);
    chk("t5_np_sticky", 64'(errNotPresent), 64'h1);
    chk("t5_walkCnt", 64'(walkCnt), 64'h5);

    // T6: walker stall, then reset mid-walk and a late fill
    walkReqRdy = 1'b0;
    set_miss(2'b01, 36'hABC, '0);             // cycle y
    exp_q.push_back(36'hABC);
    step(1);
    set_miss(2'b00, '0, '0);
    step(1);                                   // y+2 ISSUE
    chk("t6_en_y2", 64'(walkReqEn), 64'h1);
    step(1);                                   // y+3 still ISSUE
    chk("t6_hold_en", 64'(walkReqEn), 64'h1);
    chk("t6_hold_va", {28'd0, walkReqVA}, 64'hABC);
    walkReqRdy = 1'b1;
    step(1);                                   // y+4 WALK
    chk("t6_busy_walk", 64'(busy), 64'h1);
    reset = 1'b1;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'h0);
    chk("t6_rst_rdy", 64'(missRdy), 64'h3);
    chk("t6_rst_state", 64'(dbgState), 64'(IDLE));
    chk("t6_rst_errs", {62'd0, errNotPresent, errTimeout}, 64'h0);
    chk("t6_rst_errVA", {28'd0, errVA}, 64'h0);
    chk("t6_rst_cnt", 64'(walkCnt), 64'h0);
    step(1);
    reset = 1'b0;
    set_fill(1'b1, 36'hABC);
    step(1);
    set_fill(1'b0, '0);
    step(1);
    chk("t6_late_cnt", 64'(walkCnt), 64'h0);
    chk("t6_late_busy", 64'(busy), 64'h0);
    chk("t6_late_en", 64'(walkReqEn), 64'h0);
    chk("t6_late_rdy", 64'(missRdy), 64'h3);

    chk("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
